// File: rtl/seq_signed_divider.sv
// Multi-cycle signed integer divider (restoring, one quotient bit per clock).
// Works on operand magnitudes and applies the result signs in a final FIX
// cycle. Quotient truncates toward zero; Remainder takes the sign of A.
// A zero divisor finishes in one cycle with Quotient = all ones,
// Remainder = A and div_by_zero set.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;     // dividend shift register; quotient bits enter at LSB
  logic [WIDTH-1:0] dvs;     // divisor magnitude
  logic [WIDTH-1:0] prem;    // partial remainder
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Operand magnitudes and one trial-subtract step. prem < dvs <= 2^(WIDTH-1),
  // so the shifted value fits in WIDTH+1 bits and diff[WIDTH] is the borrow.
  always_comb begin
    abs_a   = A[WIDTH-1] ? -A : A;
    abs_b   = B[WIDTH-1] ? -B : B;
    shifted = {prem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (B == '0) begin
              Quotient    <= '1;
              Remainder   <= A;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              dvd    <= abs_a;
              dvs    <= abs_b;
              sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r <= A[WIDTH-1];
              prem   <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          // Commit the difference when non-negative, otherwise keep the shifted value.
          prem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          dvd  <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          Quotient    <= sign_q ? -dvd : dvd;
          Remainder   <= sign_r ? -prem : prem;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (WIDTH = 32), hand-computed vectors.
module tb_seq_signed_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic [W-1:0] Quotient, Remainder;
  logic         busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;

  seq_signed_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the start edge is the following posedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // lat = clock edges after the start edge before done is seen (0 = the
  // cycle right after the start edge); -1 on timeout. Samples on negedges.
  // inj_at > 0 drives a disturbing start (A=7,B=7) for one cycle at that count.
  task automatic wait_done(input int inj_at, output int lat, output int busy_n);
    lat = -1; busy_n = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (inj_at > 0 && n == inj_at) begin A = 7; B = 7; start = 1'b1; end
      if (inj_at > 0 && n == inj_at + 1) start = 1'b0;
      if (done) begin
        lat = n;
        chk("busy_low_in_done", {31'b0, busy}, 0);
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er);
    int lat, bn, el;
    el = (b == 0) ? 0 : LAT;
    launch(a, b);
    wait_done(0, lat, bn);
    chk({tag, "_lat"}, W'(lat), W'(el));
    chk({tag, "_busy"}, W'(bn), W'(el));
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, b == 0});
  endtask

  initial begin
    int lat, bn, seen;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_flags", {29'b0, busy, done, div_by_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and sign cases
    run("t1", 35, 7, 5, 0);
    run("neg_a", -90, 7, -12, -6);
    run("neg_b", 90, -7, -12, 6);
    run("neg_ab", -35, -5, 7, 0);
    run("small", 234, -345, 0, 234);

    // Divide by zero, then an immediate normal op
    run("dz", 13, 0, 32'hFFFF_FFFF, 13);
    run("after_dz", 80730, 345, 234, 0);

    // Edge operands
    run("min_m1", 32'h8000_0000, -1, 32'h8000_0000, 0);
    run("div1", -2432, 1, -2432, 0);
    run("zero_a", 0, -24, 0, 0);

    // Start while busy is ignored; then back-to-back from the done cycle
    launch(100, 3);
    wait_done(10, lat, bn);
    chk("ign_lat", W'(lat), W'(LAT));
    chk("ign_q", Quotient, 33);
    chk("ign_r", Remainder, 1);
    launch(-100, 3);
    wait_done(0, lat, bn);
    chk("b2b_lat", W'(lat), W'(LAT));
    chk("b2b_q", Quotient, -33);
    chk("b2b_r", Remainder, -1);

    // Asynchronous reset mid-CALC
    launch(1000, 10);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_flags", {30'b0, busy, done}, 0);
    chk("arst_q", Quotient, 0);
    chk("arst_r", Remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("arst_no_done", W'(seen), 0);
    run("post_rst", 1000, 10, 100, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
